exe_stage: RTL and testbench

//  Execute stage; consumes the ID/EXE pipeline register outputs and produces the registered EXE/MEM result.

---
 rtl/exe_pkg.sv | 39 +++
 rtl/exe_if.sv | 48 ++++
 rtl/exe_mul_iter.sv | 72 +++++++
 rtl/exe_stage.sv | 150 +++++++++++++++
 tb/tb_exe_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// ----------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage:
//   DATA_W_DEFAULT / MUL_STEP_DEFAULT  default datapath width and multiplier
//                                      bits retired per cycle
//   unit_e                             operation select codes (11-15 act as NOP)
//   state_e                            execute stage FSM states
//   is_write_unit()                    true for codes that write a register
// ----------------------------------------------------------------------------
package exe_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int MUL_STEP_DEFAULT = 2;

    typedef enum logic [3:0] {
        U_NOP  = 4'd0,
        U_ADD  = 4'd1,
        U_SUB  = 4'd2,
        U_AND  = 4'd3,
        U_OR   = 4'd4,
        U_XOR  = 4'd5,
        U_SLL  = 4'd6,
        U_SRL  = 4'd7,
        U_ADDI = 4'd8,
        U_MOVI = 4'd9,
        U_MUL  = 4'd10
    } unit_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // Codes 1..10 produce a register write; NOP and the undefined codes do not.
    function automatic logic is_write_unit(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd10);
    endfunction

endpackage

// File: rtl/exe_if.sv
// ----------------------------------------------------------------------------
// exe_if
// ID/EXE input bundle and EXE/MEM output bundle of the execute stage.
//   in_valid/in_ready     accept handshake from decode
//   unit_in               operation select (exe_pkg::unit_e)
//   in_Rd/in_Rs1/in_Rs2   destination and source register numbers
//   in_D1/in_D2           operands A and B
//   in_imm_2R1            19-bit signed immediate
//   in_imm_RI             26-bit unsigned immediate
//   out_valid/out_wr_en   EXE/MEM entry valid / register write enable
//   out_Rd/out_result     destination register and result
//   out_zero/out_neg      result flags
// Modports: master = decode/testbench side, slave = execute stage.
// ----------------------------------------------------------------------------
interface exe_if #(
    parameter int DATA_W = exe_pkg::DATA_W_DEFAULT
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        unit_in;
    logic [3:0]        in_Rd;
    logic [3:0]        in_Rs1;
    logic [3:0]        in_Rs2;
    logic [DATA_W-1:0] in_D1;
    logic [DATA_W-1:0] in_D2;
    logic [18:0]       in_imm_2R1;
    logic [25:0]       in_imm_RI;
    logic              out_valid;
    logic              out_wr_en;
    logic [3:0]        out_Rd;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_neg;

    modport master (
        output in_valid, unit_in, in_Rd, in_Rs1, in_Rs2, in_D1, in_D2,
               in_imm_2R1, in_imm_RI,
        input  in_ready, out_valid, out_wr_en, out_Rd, out_result,
               out_zero, out_neg
    );

    modport slave (
        input  in_valid, unit_in, in_Rd, in_Rs1, in_Rs2, in_D1, in_D2,
               in_imm_2R1, in_imm_RI,
        output in_ready, out_valid, out_wr_en, out_Rd, out_result,
               out_zero, out_neg
    );
endinterface

// File: rtl/exe_mul_iter.sv
// ----------------------------------------------------------------------------
// exe_mul_iter
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per clock
// (negedge). Product is truncated to DATA_W bits.
//   clk, rst_n   pipeline clock (negedge), synchronous active-low reset
//   i_start      load operands and begin (ignored while busy)
//   i_a, i_b     multiplicand / multiplier
//   o_busy       iteration in progress
//   o_done       the coming edge retires the last step; o_product is final
//   o_product    accumulator value after the coming edge
// MUL_STEP must divide DATA_W.
// ----------------------------------------------------------------------------
module exe_mul_iter
    import exe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MUL_STEP = MUL_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);
    localparam int STEPS = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [DATA_W-1:0] r_a;    // multiplicand, pre-shifted to current weight
    logic [DATA_W-1:0] r_b;    // remaining multiplier bits, LSB first
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_partial;

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_b[j]) begin
                w_partial = w_partial + (r_a << j);
            end
        end
    end

    assign o_busy    = (r_cnt != '0);
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_product = r_acc + w_partial;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start && !o_busy) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= CNT_W'(STEPS);
        end else if (o_busy) begin
            r_a   <= r_a << MUL_STEP;
            r_b   <= r_b >> MUL_STEP;
            r_acc <= o_product;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
// Execute stage: single-cycle ALU plus an iterative multiply, producing the
// registered EXE/MEM entry. State updates on the falling edge of clk, matching
// the ID/EXE register.
//   clk    pipeline clock (negedge active)
//   rst_n  synchronous active-low reset, sampled on negedge clk
//   bus    exe_if.slave: ID/EXE inputs, in_ready backpressure, EXE/MEM outputs
// Build option: define EXE_FWD_EN to bypass the previous result back into
// operand A/B when its destination matches in_Rs1/in_Rs2.
// ----------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MUL_STEP = MUL_STEP_DEFAULT
) (
    input logic  clk,
    input logic  rst_n,
    exe_if.slave bus
);
    state_e            r_state;
    logic              r_out_valid;
    logic              r_out_wr_en;
    logic [3:0]        r_out_rd;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic              r_out_neg;
    logic [3:0]        r_mul_rd;     // destination held for the whole multiply

    logic              w_accept;
    logic              w_is_mul;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_imm_s;
    logic [DATA_W-1:0] w_imm_u;
    logic [DATA_W-1:0] w_alu;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_prod;

    assign bus.in_ready = (r_state == S_IDLE);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_mul     = (bus.unit_in == U_MUL);

`ifdef EXE_FWD_EN
    // Bypass the entry currently on the EXE/MEM outputs; Rs1 and Rs2 are
    // matched independently.
    logic w_fwd_a;
    logic w_fwd_b;
    assign w_fwd_a = r_out_valid && r_out_wr_en && (r_out_rd == bus.in_Rs1);
    assign w_fwd_b = r_out_valid && r_out_wr_en && (r_out_rd == bus.in_Rs2);
    assign w_op_a  = w_fwd_a ? r_out_result : bus.in_D1;
    assign w_op_b  = w_fwd_b ? r_out_result : bus.in_D2;
    logic w_unused;
    assign w_unused = w_mul_busy;
`else
    assign w_op_a = bus.in_D1;
    assign w_op_b = bus.in_D2;
    logic w_unused;
    assign w_unused = w_mul_busy ^ (^bus.in_Rs1) ^ (^bus.in_Rs2);
`endif

    assign w_imm_s = {{(DATA_W-19){bus.in_imm_2R1[18]}}, bus.in_imm_2R1};
    assign w_imm_u = {{(DATA_W-26){1'b0}}, bus.in_imm_RI};

    // MOVI takes only the immediate, so the bypass never affects it.
    always_comb begin
        w_alu = '0;
        case (unit_e'(bus.unit_in))
            U_ADD:   w_alu = w_op_a + w_op_b;
            U_SUB:   w_alu = w_op_a - w_op_b;
            U_AND:   w_alu = w_op_a & w_op_b;
            U_OR:    w_alu = w_op_a | w_op_b;
            U_XOR:   w_alu = w_op_a ^ w_op_b;
            U_SLL:   w_alu = w_op_a << w_op_b[4:0];
            U_SRL:   w_alu = w_op_a >> w_op_b[4:0];
            U_ADDI:  w_alu = w_op_a + w_imm_s;
            U_MOVI:  w_alu = w_imm_u;
            default: w_alu = '0;
        endcase
    end

    exe_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_wr_en  <= 1'b0;
            r_out_rd     <= '0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_neg    <= 1'b0;
            r_mul_rd     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state     <= S_MUL;
                        r_mul_rd    <= bus.in_Rd;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_valid  <= 1'b1;
                        r_out_wr_en  <= is_write_unit(bus.unit_in);
                        r_out_rd     <= bus.in_Rd;
                        r_out_result <= w_alu;
                        r_out_zero   <= (w_alu == '0);
                        r_out_neg    <= w_alu[DATA_W-1];
                    end else begin
                        r_out_valid <= 1'b0;   // bubble; other outputs hold
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_state      <= S_IDLE;
                        r_out_valid  <= 1'b1;
                        r_out_wr_en  <= 1'b1;
                        r_out_rd     <= r_mul_rd;
                        r_out_result <= w_mul_prod;
                        r_out_zero   <= (w_mul_prod == '0);
                        r_out_neg    <= w_mul_prod[DATA_W-1];
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_wr_en  = r_out_wr_en;
    assign bus.out_Rd     = r_out_rd;
    assign bus.out_result = r_out_result;
    assign bus.out_zero   = r_out_zero;
    assign bus.out_neg    = r_out_neg;
endmodule

// File: tb/tb_exe_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_stage
// Directed testbench for exe_stage at DATA_W=32, MUL_STEP=2. Inputs change
// and outputs are sampled on the rising edge, half a cycle away from the
// active falling edge.
// ----------------------------------------------------------------------------
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_fail = 0;

    exe_if #(.DATA_W(32)) bus ();

    exe_stage #(.DATA_W(32), .MUL_STEP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance past one active (falling) edge and stop at the next rising edge.
    task automatic tick;
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] unit, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [18:0] i2r1, input logic [25:0] iri);
        bus.in_valid   = 1'b1;
        bus.unit_in    = unit;
        bus.in_Rd      = rd;
        bus.in_Rs1     = rs1;
        bus.in_Rs2     = rs2;
        bus.in_D1      = d1;
        bus.in_D2      = d2;
        bus.in_imm_2R1 = i2r1;
        bus.in_imm_RI  = iri;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [3:0] rd,
                             input logic wr_en, input logic zero, input logic neg);
        check({tag, ".valid"},  32'(bus.out_valid), 32'd1);
        check({tag, ".result"}, bus.out_result,     res);
        check({tag, ".rd"},     32'(bus.out_Rd),    32'(rd));
        check({tag, ".wr_en"},  32'(bus.out_wr_en), 32'(wr_en));
        check({tag, ".zero"},   32'(bus.out_zero),  32'(zero));
        check({tag, ".neg"},    32'(bus.out_neg),   32'(neg));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, ".valid"},    32'(bus.out_valid), 32'd0);
        check({tag, ".wr_en"},    32'(bus.out_wr_en), 32'd0);
        check({tag, ".rd"},       32'(bus.out_Rd),    32'd0);
        check({tag, ".result"},   bus.out_result,     32'd0);
        check({tag, ".zero"},     32'(bus.out_zero),  32'd0);
        check({tag, ".neg"},      32'(bus.out_neg),   32'd0);
    endtask

    initial begin
        int busy_cycles;
        int seen_valid;

        rst_n = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 19'd0, 26'd0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;

        // ADD 5+7 -> 12
        drive(4'd1, 4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 19'd0, 26'd0);
        tick();
        check_out("add", 32'd12, 4'd3, 1'b1, 1'b0, 1'b0);

        // Bubble: out_valid drops, result holds
        bus.in_valid = 1'b0;
        tick();
        check("bubble.valid",  32'(bus.out_valid), 32'd0);
        check("bubble.result", bus.out_result,     32'd12);

        // SUB 1-1 -> 0 (zero flag), SUB 0-1 -> all ones (neg flag)
        drive(4'd2, 4'd5, 4'd0, 4'd0, 32'd1, 32'd1, 19'd0, 26'd0);
        tick();
        check_out("sub_zero", 32'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        drive(4'd2, 4'd5, 4'd0, 4'd0, 32'd0, 32'd1, 19'd0, 26'd0);
        tick();
        check_out("sub_neg", 32'hFFFF_FFFF, 4'd5, 1'b1, 1'b0, 1'b1);

        // ADDI 10 + (-1) -> 9; MOVI zero-extends the 26-bit immediate
        drive(4'd8, 4'd6, 4'd0, 4'd0, 32'd10, 32'd0, 19'h7FFFF, 26'd0);
        tick();
        check_out("addi", 32'd9, 4'd6, 1'b1, 1'b0, 1'b0);
        drive(4'd9, 4'd6, 4'd0, 4'd0, 32'h1234, 32'h5678, 19'd0, 26'h3FF_FFFF);
        tick();
        check_out("movi", 32'h03FF_FFFF, 4'd6, 1'b1, 1'b0, 1'b0);

        // Shifts use D2[4:0] only; XOR
        drive(4'd6, 4'd2, 4'd0, 4'd0, 32'd1, 32'h24, 19'd0, 26'd0);
        tick();
        check("sll.result", bus.out_result, 32'd16);
        drive(4'd7, 4'd2, 4'd0, 4'd0, 32'h8000_0000, 32'd31, 19'd0, 26'd0);
        tick();
        check("srl.result", bus.out_result, 32'd1);
        drive(4'd5, 4'd2, 4'd0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 19'd0, 26'd0);
        tick();
        check("xor.result", bus.out_result, 32'h0000_0FF0);

        // Undefined code acts as NOP: valid, no write, zero result
        drive(4'd13, 4'd2, 4'd0, 4'd0, 32'd5, 32'd7, 19'd0, 26'd0);
        tick();
        check_out("nop13", 32'd0, 4'd2, 1'b0, 1'b1, 1'b0);

        // MUL 0x10001 * 3 with an ADD held behind it
        drive(4'd10, 4'd7, 4'd0, 4'd0, 32'h0001_0001, 32'd3, 19'd0, 26'd0);
        tick();
        drive(4'd1, 4'd8, 4'd0, 4'd0, 32'd2, 32'd3, 19'd0, 26'd0);
        busy_cycles = 0;
        seen_valid  = 0;
        while (!bus.in_ready && busy_cycles < 40) begin
            if (bus.out_valid) seen_valid++;
            busy_cycles++;
            tick();
        end
        check("mul.busy_cycles", 32'(busy_cycles), 32'd16);
        check("mul.valid_while_busy", 32'(seen_valid), 32'd0);
        check_out("mul", 32'h0003_0003, 4'd7, 1'b1, 1'b0, 1'b0);
        check("mul.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("held_add", 32'd5, 4'd8, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply aborts it
        drive(4'd10, 4'd9, 4'd0, 4'd0, 32'h0001_0001, 32'd3, 19'd0, 26'd0);
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        check("abort.in_ready_before", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("abort_reset");
        seen_valid = 0;
        repeat (24) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        check("abort.no_result", 32'(seen_valid), 32'd0);

        // Back-to-back dependent ADDs exercise the bypass
        drive(4'd1, 4'd4, 4'd0, 4'd0, 32'd15, 32'd5, 19'd0, 26'd0);
        tick();
        check("fwd_src.result", bus.out_result, 32'd20);
        drive(4'd1, 4'd10, 4'd4, 4'd0, 32'd0, 32'd1, 19'd0, 26'd0);
        tick();
`ifdef EXE_FWD_EN
        check("fwd_rs1.result", bus.out_result, 32'd21);
`else
        check("fwd_rs1.result", bus.out_result, 32'd1);
`endif
        drive(4'd1, 4'd11, 4'd0, 4'd10, 32'd1, 32'd0, 19'd0, 26'd0);
        tick();
`ifdef EXE_FWD_EN
        check("fwd_rs2.result", bus.out_result, 32'd22);
`else
        check("fwd_rs2.result", bus.out_result, 32'd1);
`endif
        bus.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
